// File: rtl/fft_os_framer.sv
// Overlap-save input framer: collects NFFT/2 fresh samples per hop and streams
// history+fresh as one NFFT-point block into the FFT load handshake.
module fft_os_framer #(
    parameter int NFFT = 32,
    parameter int W    = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_x_re,
    input  logic [W-1:0] i_x_im,
    output logic         o_in_ready,
    output logic         o_start,
    input  logic         i_fft_ready,
    output logic         o_valid,
    output logic [W-1:0] o_x_re,
    output logic [W-1:0] o_x_im,
    output logic         o_last,
    output logic         o_busy
);

    localparam int HALF = NFFT / 2;
    localparam int AW   = $clog2(NFFT);
    localparam int HW   = AW - 1;
    localparam logic [HW-1:0] FILL_LAST = HW'(HALF - 1);
    localparam logic [AW-1:0] SEND_LAST = AW'(NFFT - 1);

    typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_SEND} state_t;

    state_t        state_q;
    logic [HW-1:0] fill_cnt_q;
    logic [AW-1:0] send_cnt_q;
    logic          bank_new_q;
    logic          start_q, valid_q, last_q;
    logic [W-1:0]  x_re_q, x_im_q;
    logic [W-1:0]  mem_re_q [2][HALF];
    logic [W-1:0]  mem_im_q [2][HALF];

    logic [AW-1:0] rd_idx_d;
    logic          rd_bank_d;
    logic [HW-1:0] rd_addr_d;
    logic [W-1:0]  rd_re_d, rd_im_d;
    logic          xfer_d;

    // Read port looks one sample ahead so o_x can be registered on each transfer.
    // Lower half of the block comes from the history bank, upper half from the fill bank.
    always_comb begin
        rd_idx_d  = (state_q == S_SEND) ? send_cnt_q + 1'b1 : '0;
        rd_bank_d = rd_idx_d[AW-1] ? bank_new_q : ~bank_new_q;
        rd_addr_d = rd_idx_d[HW-1:0];
        rd_re_d   = mem_re_q[rd_bank_d][rd_addr_d];
        rd_im_d   = mem_im_q[rd_bank_d][rd_addr_d];
        xfer_d    = valid_q & i_fft_ready;
    end

    // NOTE: sequential state uses non-blocking assignments only; the sample banks
    // are reset as well because the first block must see an all-zero history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_FILL;
            fill_cnt_q <= '0;
            send_cnt_q <= '0;
            bank_new_q <= 1'b0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            x_re_q     <= '0;
            x_im_q     <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < HALF; a++) begin
                    mem_re_q[b][a] <= '0;
                    mem_im_q[b][a] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_FILL: begin
                    if (i_valid) begin
                        mem_re_q[bank_new_q][fill_cnt_q] <= i_x_re;
                        mem_im_q[bank_new_q][fill_cnt_q] <= i_x_im;
                        if (fill_cnt_q == FILL_LAST) begin
                            fill_cnt_q <= '0;
                            start_q    <= 1'b1;
                            state_q    <= S_START;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_fft_ready) begin
                        send_cnt_q <= '0;
                        valid_q    <= 1'b1;
                        last_q     <= 1'b0;
                        x_re_q     <= rd_re_d;
                        x_im_q     <= rd_im_d;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (xfer_d) begin
                        if (send_cnt_q == SEND_LAST) begin
                            valid_q    <= 1'b0;
                            last_q     <= 1'b0;
                            send_cnt_q <= '0;
                            bank_new_q <= ~bank_new_q;
                            state_q    <= S_FILL;
                        end else begin
                            send_cnt_q <= rd_idx_d;
                            x_re_q     <= rd_re_d;
                            x_im_q     <= rd_im_d;
                            last_q     <= (rd_idx_d == SEND_LAST);
                        end
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign o_in_ready = i_rst_n & (state_q == S_FILL);
    assign o_busy     = (state_q != S_FILL);
    assign o_start    = start_q;
    assign o_valid    = valid_q;
    assign o_last     = last_q;
    assign o_x_re     = x_re_q;
    assign o_x_im     = x_im_q;

endmodule

// File: tb/tb_fft_os_framer.sv
// Directed bench for fft_os_framer: table of hops with expected block contents,
// plus hand sequences for mid-fill and mid-send resets.
module tb_fft_os_framer;

    localparam int NFFT = 32;
    localparam int W    = 16;
    localparam int HALF = NFFT / 2;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_x_re = '0;
    logic [W-1:0] i_x_im = '0;
    logic         i_fft_ready = 1'b0;
    logic         o_in_ready, o_start, o_valid, o_last, o_busy;
    logic [W-1:0] o_x_re, o_x_im;

    fft_os_framer #(.NFFT(NFFT), .W(W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_x_re      (i_x_re),
        .i_x_im      (i_x_im),
        .o_in_ready  (o_in_ready),
        .o_start     (o_start),
        .i_fft_ready (i_fft_ready),
        .o_valid     (o_valid),
        .o_x_re      (o_x_re),
        .o_x_im      (o_x_im),
        .o_last      (o_last),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // in_base: first fresh value; hist_base: first history value (0 = zero history);
    // stall_k: index at which ready drops for 3 cycles (-1 = none); junk: drive
    // i_valid with garbage while the block is being issued.
    typedef struct {
        int in_base;
        int hist_base;
        int stall_k;
        bit junk;
    } vec_t;

    vec_t vecs [4];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_re(input vec_t v, input int k);
        if (k < HALF) return (v.hist_base == 0) ? '0 : W'(v.hist_base + k);
        return W'(v.in_base + k - HALF);
    endfunction

    function automatic logic [W-1:0] exp_im(input vec_t v, input int k);
        if (k < HALF && v.hist_base == 0) return '0;
        return exp_re(v, k) ^ 16'hA5A5;
    endfunction

    task automatic feed(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            check("in_ready_fill", o_in_ready, 1);
            i_valid = 1'b1;
            i_x_re  = W'(base + i);
            i_x_im  = W'(base + i) ^ 16'hA5A5;
        end
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_start"}, o_start, 0);
        check({tag, "_last"}, o_last, 0);
        check({tag, "_x_re"}, o_x_re, 0);
        check({tag, "_x_im"}, o_x_im, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_in_ready"}, o_in_ready, 0);
    endtask

    task automatic run_block(input vec_t v);
        int  count  = 0;
        int  cycles = 2;
        int  stalls = 0;
        bit  seen   = 1'b0;
        feed(v.in_base, HALF);
        @(negedge i_clk);
        check("start_pulse", o_start, 1);
        check("in_ready_start", o_in_ready, 0);
        check("busy_start", o_busy, 1);
        check("valid_start", o_valid, 0);
        i_valid     = v.junk;
        i_x_re      = 16'h7F01;
        i_x_im      = 16'h7F81;
        i_fft_ready = 1'b1;
        @(negedge i_clk);
        check("start_one_cycle", o_start, 0);
        check("valid_wait", o_valid, 0);
        i_x_re = 16'h7F02;
        while (count < NFFT && cycles < 200) begin
            @(negedge i_clk);
            cycles++;
            if (v.junk) begin
                i_x_re = W'(32'h7F00 + cycles);
                i_x_im = W'(32'h7E00 + cycles);
                check("in_ready_busy", o_in_ready, 0);
            end
            check("start_in_send", o_start, 0);
            if (o_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("first_valid_lat", cycles, 3);
                end
                check($sformatf("re_k%0d_base%0d", count, v.in_base), o_x_re, exp_re(v, count));
                check($sformatf("im_k%0d_base%0d", count, v.in_base), o_x_im, exp_im(v, count));
                check($sformatf("last_k%0d", count), o_last, (count == NFFT - 1));
                if (count == v.stall_k && stalls < 3) begin
                    i_fft_ready = 1'b0;
                    stalls++;
                end else begin
                    i_fft_ready = 1'b1;
                    count++;
                end
            end
        end
        check("xfer_count", count, NFFT);
        check("last_xfer_time", cycles, NFFT + 2 + stalls);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("valid_after_block", o_valid, 0);
        check("last_after_block", o_last, 0);
        check("in_ready_after_block", o_in_ready, 1);
        check("busy_after_block", o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{in_base: 1,  hist_base: 0,  stall_k: 20, junk: 1'b0};
        vecs[1] = '{in_base: 17, hist_base: 1,  stall_k: -1, junk: 1'b0};
        vecs[2] = '{in_base: 33, hist_base: 17, stall_k: 0,  junk: 1'b1};
        vecs[3] = '{in_base: 49, hist_base: 33, stall_k: 31, junk: 1'b1};

        #12;
        outputs_zero("rst_init");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("in_ready_release", o_in_ready, 1);
        check("busy_release", o_busy, 0);

        for (int i = 0; i < 4; i++) run_block(vecs[i]);

        // Reset part-way through a fill: partial samples and history must vanish.
        feed(300, 5);
        @(negedge i_clk);
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 outputs_zero("rst_fill");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_block('{in_base: 201, hist_base: 0, stall_k: -1, junk: 1'b0});

        // Reset part-way through a send, with non-zero outputs on the bus.
        feed(400, HALF);
        @(negedge i_clk);
        i_valid     = 1'b0;
        i_fft_ready = 1'b1;
        repeat (5) @(negedge i_clk);
        check("pre_reset_valid", o_valid, 1);
        #2 i_rst_n = 1'b0;
        #1 outputs_zero("rst_send");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_block('{in_base: 501, hist_base: 0, stall_k: -1, junk: 1'b0});
        run_block('{in_base: 517, hist_base: 501, stall_k: 7, junk: 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
